// File: rtl/mem_types.sv
// Memory command encoding and the copy-engine state encoding, shared with the bench.
package mem_types;
    typedef enum logic [1:0] {NONE = 2'd0, READ = 2'd1, WRITE = 2'd2} cmd_t;
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_CAPTURE, WR_CMD, WR_HOLD, DONE} copy_state_t;
endpackage

// File: rtl/register_types.sv
// Register-level shared types: byte address width and address type.
package register_types;
    localparam int ADDR_W = 16;
    typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/mem.sv
// Command adapter between mem_copy and a synchronous SRAM: READ goes to the SRAM in the
// same cycle, WRITE is registered and driven onto the SRAM during the following cycle.
module mem
    import mem_types::*;
    import register_types::*;
(
    input  logic       clk,
    input  logic       reset,
    input  cmd_t       cmd,
    input  addr_t      addr,
    input  logic [7:0] write_data,
    output logic [7:0] read_data,
    output logic       sram_ce,
    output logic       sram_we,
    output addr_t      sram_addr,
    output logic [7:0] sram_wdata,
    input  logic [7:0] sram_rdata
);
    logic       wr_pend_q, wr_pend_d;
    addr_t      wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;

    always_comb begin
        wr_pend_d = (cmd == WRITE);
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (cmd == WRITE) begin
            wr_addr_d = addr;
            wr_data_d = write_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'd0;
        end else begin
            wr_pend_q <= wr_pend_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign sram_ce    = wr_pend_q | (cmd == READ);
    assign sram_we    = wr_pend_q;
    assign sram_addr  = wr_pend_q ? wr_addr_q : addr;
    assign sram_wdata = wr_data_q;
    assign read_data  = sram_rdata;
endmodule

// File: rtl/sram.sv
// Single-port synchronous byte SRAM, 64K deep, with a load port for preloading contents.
module sram
    import register_types::*;
(
    input  logic       clk,
    input  logic       ce,
    input  logic       we,
    input  addr_t      addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    input  logic       load_en,
    input  addr_t      load_addr,
    input  logic [7:0] load_data
);
    logic [7:0] ram_q [0:65535];
    logic [7:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (!load_en && ce && !we) rdata_d = ram_q[addr];
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (load_en)
            ram_q[load_addr] <= load_data;
        else if (ce && we)
            ram_q[addr] <= wdata;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/mem_copy.sv
// Byte-by-byte memory copy engine (4 cycles/byte) driving the mem command port.
// MEM_COPY_FILL_EN adds a fill mode writing fill_value at 2 cycles/byte with no reads.
//   state      | meaning
//   IDLE       | waiting for start
//   RD_ADDR    | READ issued at current source
//   RD_CAPTURE | read data captured
//   WR_CMD     | WRITE issued at current destination
//   WR_HOLD    | mem writes the SRAM; advance pointers
//   DONE       | one-cycle completion pulse
module mem_copy
    import mem_types::*;
    import register_types::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  addr_t       src,
    input  addr_t       dst,
    input  logic [15:0] len,
`ifdef MEM_COPY_FILL_EN
    input  logic        fill,
    input  logic [7:0]  fill_value,
`endif
    output logic        busy,
    output logic        done,
    output cmd_t        cmd,
    output addr_t       addr,
    output logic [7:0]  write_data,
    input  logic [7:0]  read_data
);
    copy_state_t state_q, state_d;
    addr_t       src_q, src_d, dst_q, dst_d, addr_q, addr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  data_q, data_d, wdata_q, wdata_d;
    cmd_t        cmd_q, cmd_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic        use_fill;
`ifdef MEM_COPY_FILL_EN
    logic        fill_q, fill_d;
    logic [7:0]  fval_q, fval_d;
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
`ifdef MEM_COPY_FILL_EN
        fill_d   = fill_q;
        fval_d   = fval_q;
        use_fill = (state_q == IDLE) ? fill : fill_q;
`else
        use_fill = 1'b0;
`endif
        case (state_q)
            IDLE: if (start) begin
                src_d = src;
                dst_d = dst;
                cnt_d = len;
`ifdef MEM_COPY_FILL_EN
                fill_d = fill;
                fval_d = fill_value;
`endif
                if (len == 16'd0)  state_d = DONE;
                else if (use_fill) state_d = WR_CMD;
                else               state_d = RD_ADDR;
            end
            RD_ADDR:    state_d = RD_CAPTURE;
            RD_CAPTURE: begin
                data_d  = read_data;
                state_d = WR_CMD;
            end
            WR_CMD:     state_d = WR_HOLD;
            WR_HOLD: begin
                src_d = src_q + 16'd1;
                dst_d = dst_q + 16'd1;
                cnt_d = cnt_q - 16'd1;
                if (cnt_q == 16'd1) state_d = DONE;
                else if (use_fill)  state_d = WR_CMD;
                else                state_d = RD_ADDR;
            end
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered alongside it.
        cmd_d   = NONE;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        case (state_d)
            IDLE:    wdata_d = 8'd0;
            RD_ADDR: begin
                cmd_d  = READ;
                addr_d = src_d;
            end
            WR_CMD: begin
                cmd_d  = WRITE;
                addr_d = dst_d;
`ifdef MEM_COPY_FILL_EN
                wdata_d = use_fill ? fval_d : data_d;
`else
                wdata_d = data_d;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= 16'd0;
            data_q  <= 8'd0;
            cmd_q   <= NONE;
            addr_q  <= '0;
            wdata_q <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MEM_COPY_FILL_EN
            fill_q  <= 1'b0;
            fval_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MEM_COPY_FILL_EN
            fill_q  <= fill_d;
            fval_q  <= fval_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign cmd        = cmd_q;
    assign addr       = addr_q;
    assign write_data = wdata_q;
endmodule

// File: tb/tb_mem_copy.sv
// Directed bench for mem_copy driving mem and an SRAM model; build with MEM_COPY_FILL_EN for fill mode.
module tb_mem_copy;
    import mem_types::*;
    import register_types::*;

    logic        clk = 1'b0;
    logic        reset, start;
    addr_t       src, dst, addr;
    logic [15:0] len;
    logic        busy, done;
    cmd_t        cmd;
    logic [7:0]  write_data, read_data;
    logic        sram_ce, sram_we, load_en;
    addr_t       sram_addr, load_addr;
    logic [7:0]  sram_wdata, sram_rdata, load_data;
`ifdef MEM_COPY_FILL_EN
    logic        fill;
    logic [7:0]  fill_value;
`endif

    int    n_checks = 0;
    int    n_errors = 0;
    int    n_rd = 0, n_wr = 0, n_ww = 0;
    logic  prev_wr = 1'b0;
    addr_t rd_log [8];
    addr_t wr_log [8];
    int    d_at, b_cnt;

    always #5 clk = ~clk;

    mem_copy u_dut (
        .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
`ifdef MEM_COPY_FILL_EN
        .fill(fill), .fill_value(fill_value),
`endif
        .busy(busy), .done(done), .cmd(cmd), .addr(addr),
        .write_data(write_data), .read_data(read_data)
    );

    mem u_mem (
        .clk(clk), .reset(reset), .cmd(cmd), .addr(addr), .write_data(write_data),
        .read_data(read_data), .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    sram u_sram (
        .clk(clk), .ce(sram_ce), .we(sram_we), .addr(sram_addr), .wdata(sram_wdata),
        .rdata(sram_rdata), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    // Command monitor: logs issued addresses and counts back-to-back WRITEs.
    always @(negedge clk) begin
        if (cmd == READ) begin
            if (n_rd < 8) rd_log[n_rd] = addr;
            n_rd++;
        end
        if (cmd == WRITE) begin
            if (n_wr < 8) wr_log[n_wr] = addr;
            n_wr++;
            if (prev_wr) n_ww++;
        end
        prev_wr = (cmd == WRITE);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] peek(input addr_t a);
        return u_sram.ram_q[a];
    endfunction

    task automatic load(input addr_t a, input logic [7:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Returns at the sample point of cycle 1 (first cycle after the start edge).
    task automatic launch(input addr_t s, input addr_t d, input logic [15:0] l);
        @(negedge clk);
        n_rd = 0; n_wr = 0; n_ww = 0; prev_wr = 1'b0;
        start = 1'b1; src = s; dst = d; len = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Walks cycles from 1 until busy drops; optionally pulses start with other operands.
    task automatic track(input int glitch_at, output int done_at, output int busy_cnt);
        done_at = 0; busy_cnt = 0;
        for (int k = 1; k <= 200; k++) begin
            if (done && done_at == 0) done_at = k;
            if (!busy) break;
            busy_cnt++;
            if (k == glitch_at) begin
                start = 1'b1; src = 16'h0050; dst = 16'h0500; len = 16'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; src = '0; dst = '0; len = 16'd0;
        load_en = 1'b0; load_addr = '0; load_data = 8'd0;
`ifdef MEM_COPY_FILL_EN
        fill = 1'b0; fill_value = 8'd0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cmd", 32'(cmd), 32'(NONE));
        chk("rst_addr", 32'(addr), 0);
        chk("rst_wdata", 32'(write_data), 0);
        reset = 1'b0;

        // Basic 3-byte copy
        load(16'h0010, 8'hA1); load(16'h0011, 8'hB2); load(16'h0012, 8'hC3);
        launch(16'h0010, 16'h0100, 16'd3);
        track(0, d_at, b_cnt);
        chk("t1_done_cycle", d_at, 13);
        chk("t1_busy_cycles", b_cnt, 13);
        chk("t1_m100", 32'(peek(16'h0100)), 'hA1);
        chk("t1_m101", 32'(peek(16'h0101)), 'hB2);
        chk("t1_m102", 32'(peek(16'h0102)), 'hC3);
        chk("t1_reads", n_rd, 3);
        chk("t1_b2b_write", n_ww, 0);
        chk("t1_idle_wdata", 32'(write_data), 0);
        chk("t1_idle_cmd", 32'(cmd), 32'(NONE));

        // Zero-length transfer
        launch(16'h0010, 16'h0120, 16'd0);
        track(0, d_at, b_cnt);
        chk("t2_done_cycle", d_at, 1);
        chk("t2_busy_cycles", b_cnt, 1);
        chk("t2_reads", n_rd, 0);
        chk("t2_writes", n_wr, 0);

        // Address wrap at 0xFFFF
        load(16'hFFFF, 8'h11); load(16'h0000, 8'h22);
        launch(16'hFFFF, 16'h7FFF, 16'd2);
        track(0, d_at, b_cnt);
        chk("t3_done_cycle", d_at, 9);
        chk("t3_rd0", 32'(rd_log[0]), 'hFFFF);
        chk("t3_rd1", 32'(rd_log[1]), 'h0000);
        chk("t3_wr0", 32'(wr_log[0]), 'h7FFF);
        chk("t3_wr1", 32'(wr_log[1]), 'h8000);
        chk("t3_m7fff", 32'(peek(16'h7FFF)), 'h11);
        chk("t3_m8000", 32'(peek(16'h8000)), 'h22);

        // Reset during WR_HOLD of byte 2 of 4
        load(16'h0030, 8'h01); load(16'h0031, 8'h02); load(16'h0032, 8'h03); load(16'h0033, 8'h04);
        load(16'h0300, 8'hEE); load(16'h0301, 8'hEE); load(16'h0302, 8'hEE); load(16'h0303, 8'hEE);
        launch(16'h0030, 16'h0300, 16'd4);
        repeat (7) @(negedge clk);
        chk("t4_pre_busy", 32'(busy), 1);
        chk("t4_pre_addr", 32'(addr), 'h0301);
        #1 reset = 1'b1;
        #1;
        chk("t4_rst_busy", 32'(busy), 0);
        chk("t4_rst_cmd", 32'(cmd), 32'(NONE));
        chk("t4_rst_addr", 32'(addr), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_idle_busy", 32'(busy), 0);
        chk("t4_m300", 32'(peek(16'h0300)), 'h01);
        chk("t4_m302", 32'(peek(16'h0302)), 'hEE);
        chk("t4_m303", 32'(peek(16'h0303)), 'hEE);
        launch(16'h0030, 16'h0310, 16'd2);
        track(0, d_at, b_cnt);
        chk("t4_next_done", d_at, 9);
        chk("t4_m310", 32'(peek(16'h0310)), 'h01);
        chk("t4_m311", 32'(peek(16'h0311)), 'h02);

        // start pulsed while busy with different operands
        load(16'h0040, 8'h55); load(16'h0041, 8'h66); load(16'h0050, 8'h77); load(16'h0500, 8'hEE);
        launch(16'h0040, 16'h0400, 16'd2);
        track(3, d_at, b_cnt);
        chk("t5_done_cycle", d_at, 9);
        chk("t5_busy_cycles", b_cnt, 9);
        chk("t5_m400", 32'(peek(16'h0400)), 'h55);
        chk("t5_m401", 32'(peek(16'h0401)), 'h66);
        chk("t5_m500", 32'(peek(16'h0500)), 'hEE);
        chk("t5_reads", n_rd, 2);
        chk("t5_rd1", 32'(rd_log[1]), 'h0041);

`ifdef MEM_COPY_FILL_EN
        // Fill mode
        fill = 1'b1; fill_value = 8'h5A;
        launch(16'h0010, 16'h0200, 16'd4);
        track(0, d_at, b_cnt);
        fill = 1'b0;
        chk("t6_done_cycle", d_at, 9);
        chk("t6_busy_cycles", b_cnt, 9);
        chk("t6_reads", n_rd, 0);
        chk("t6_writes", n_wr, 4);
        chk("t6_b2b_write", n_ww, 0);
        chk("t6_m200", 32'(peek(16'h0200)), 'h5A);
        chk("t6_m201", 32'(peek(16'h0201)), 'h5A);
        chk("t6_m202", 32'(peek(16'h0202)), 'h5A);
        chk("t6_m203", 32'(peek(16'h0203)), 'h5A);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
